// File: rtl/writeback_pkg.sv
// Shared types for the register-file write-back path: queue entry layout,
// load size encodings and the per-cycle push limit.
package writeback_pkg;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  localparam logic [1:0] LD_BYTE = 2'd0;
  localparam logic [1:0] LD_HALF = 2'd1;
  localparam logic [1:0] LD_WORD = 2'd2;

  localparam int WB_PUSH_MAX = 3;

endpackage

// File: rtl/writeback_if.sv
// Register-file write port between the write-back unit (master) and the
// decoder's register file (slave).
interface writeback_if;
  logic        reg_we_out;
  logic [4:0]  rd_out;
  logic [31:0] reg_wdata;

  modport master (output reg_we_out, rd_out, reg_wdata);
  modport slave  (input  reg_we_out, rd_out, reg_wdata);
endinterface

// File: rtl/writeback_fifo.sv
// In-order write-back queue: up to WB_PUSH_MAX pushes and one pop per cycle.
// When empty, the first push bypasses storage so it reaches the output next cycle.
module writeback_fifo
  import writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pop_i,
  input  logic [WB_PUSH_MAX-1:0] push_vld_i,
  input  wb_entry_t              push_ent_i [WB_PUSH_MAX],
  output logic                   out_vld_o,
  output wb_entry_t              out_ent_o,
  output logic                   drop_o,
  output logic [CW-1:0]          count_o,
  output wb_entry_t              ord_o [DEPTH]
);

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_s;
  logic [CW-1:0] count_q, count_d;

  // Pop the old head first, then place pushes in source order into freed space.
  always_comb begin
    mem_d     = mem_q;
    head_d    = head_q;
    count_d   = count_q;
    out_vld_o = 1'b0;
    out_ent_o = '0;
    drop_o    = 1'b0;
    tail_s    = head_q + count_q[AW-1:0];
    if (pop_i && (count_q != '0)) begin
      out_vld_o = 1'b1;
      out_ent_o = mem_q[head_q];
      head_d    = head_q + AW'(1);
      count_d   = count_q - CW'(1);
    end else begin
      head_d    = head_q;
    end
    for (int k = 0; k < WB_PUSH_MAX; k++) begin
      if (push_vld_i[k]) begin
        if (pop_i && !out_vld_o) begin
          out_vld_o = 1'b1;
          out_ent_o = push_ent_i[k];
        end else if (count_d < CW'(DEPTH)) begin
          mem_d[tail_s] = push_ent_i[k];
          tail_s        = tail_s + AW'(1);
          count_d       = count_d + CW'(1);
        end else begin
          drop_o = 1'b1;
        end
      end else begin
        tail_s = tail_s;
      end
    end
  end

  // Queue state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  // Entries re-ordered oldest-first for the forwarding search.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ord_o[i] = mem_q[head_q + AW'(i)];
  end

  assign count_o = count_q;

endmodule

// File: rtl/writeback.sv
// Write-back unit: merges DIV/LD/EX results, formats loads and serialises them
// into one register write per cycle. Optional forwarding under WB_FORWARD_EN.
module writeback
  import writeback_pkg::*;
#(
  parameter int WB_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic         ex_we,
  input  logic [4:0]   ex_rd,
  input  logic [31:0]  ex_data,
  input  logic         ld_valid,
  input  logic [4:0]   ld_rd,
  input  logic [31:0]  ld_data,
  input  logic [1:0]   ld_addr_lo,
  input  logic [1:0]   ld_bytes,
  input  logic         ld_unsigned,
  input  logic         div_ready,
  input  logic [4:0]   div_rd,
  input  logic [31:0]  div_data,
  writeback_if.master  wb,
  output logic         wb_busy,
  output logic         wb_overflow,
  input  logic [4:0]   fwd_rs,
  output logic         fwd_hit,
  output logic [31:0]  fwd_data
);

  localparam int CW = $clog2(WB_DEPTH) + 1;

  function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [1:0] lo,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] sh;
    logic [31:0] r;
    sh = d;
    case (sz)
      LD_BYTE: begin
        sh = d >> {lo, 3'b000};
        r  = {{24{~uns & sh[7]}}, sh[7:0]};
      end
      LD_HALF: begin
        sh = d >> {lo[1], 4'b0000};
        r  = {{16{~uns & sh[15]}}, sh[15:0]};
      end
      default: r = d;
    endcase
    return r;
  endfunction

  logic [WB_PUSH_MAX-1:0] push_vld_s;
  wb_entry_t              push_ent_s [WB_PUSH_MAX];
  logic                   out_vld_s, drop_s;
  wb_entry_t              out_ent_s;
  logic [CW-1:0]          count_s;
  wb_entry_t              ord_s [WB_DEPTH];

  logic        we_q, ovf_q;
  logic [4:0]  rd_q;
  logic [31:0] wdata_q;

  // Slot order is program order: DIV oldest, then LD, then EX.
  always_comb begin
    push_vld_s[0] = run & div_ready & (div_rd != 5'd0);
    push_ent_s[0] = '{rd: div_rd, data: div_data};
    push_vld_s[1] = run & ld_valid & (ld_rd != 5'd0);
    push_ent_s[1] = '{rd: ld_rd, data: fmt_load(ld_data, ld_addr_lo, ld_bytes, ld_unsigned)};
    push_vld_s[2] = run & ex_we & (ex_rd != 5'd0);
    push_ent_s[2] = '{rd: ex_rd, data: ex_data};
  end

  writeback_fifo #(.DEPTH(WB_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .pop_i      (run),
    .push_vld_i (push_vld_s),
    .push_ent_i (push_ent_s),
    .out_vld_o  (out_vld_s),
    .out_ent_o  (out_ent_s),
    .drop_o     (drop_s),
    .count_o    (count_s),
    .ord_o      (ord_s)
  );

  // Register-file write port and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      rd_q    <= 5'd0;
      wdata_q <= 32'd0;
      ovf_q   <= 1'b0;
    end else begin
      we_q  <= out_vld_s;
      ovf_q <= ovf_q | drop_s;
      if (out_vld_s) begin
        rd_q    <= out_ent_s.rd;
        wdata_q <= out_ent_s.data;
      end
    end
  end

  assign wb.reg_we_out = we_q;
  assign wb.rd_out     = rd_q;
  assign wb.reg_wdata  = wdata_q;
  assign wb_overflow   = ovf_q;
  assign wb_busy       = (CW'(WB_DEPTH) - count_s) < CW'(WB_PUSH_MAX);

`ifdef WB_FORWARD_EN
  // Output register has lowest priority; younger queue entries override older ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 32'd0;
    if (fwd_rs != 5'd0) begin
      if (we_q && (rd_q == fwd_rs)) begin
        fwd_hit  = 1'b1;
        fwd_data = wdata_q;
      end else begin
        fwd_hit  = 1'b0;
      end
      for (int i = 0; i < WB_DEPTH; i++) begin
        if ((CW'(i) < count_s) && (ord_s[i].rd == fwd_rs)) begin
          fwd_hit  = 1'b1;
          fwd_data = ord_s[i].data;
        end else begin
          fwd_data = fwd_data;
        end
      end
    end else begin
      fwd_hit = 1'b0;
    end
  end
`else
  logic fwd_unused_s;

  always_comb begin
    fwd_unused_s = ^fwd_rs;
    for (int i = 0; i < WB_DEPTH; i++) fwd_unused_s = fwd_unused_s ^ (^ord_s[i]);
  end

  assign fwd_hit  = 1'b0;
  assign fwd_data = 32'd0;
`endif

endmodule

// File: tb/tb_writeback.sv
// Directed self-checking bench for writeback (default WB_DEPTH=4); forwarding
// expectations follow WB_FORWARD_EN.
module tb_writeback;
  import writeback_pkg::*;

  logic        clk = 1'b0;
  logic        reset, run;
  logic        ex_we, ld_valid, ld_unsigned, div_ready;
  logic [4:0]  ex_rd, ld_rd, div_rd, fwd_rs;
  logic [31:0] ex_data, ld_data, div_data;
  logic [1:0]  ld_addr_lo, ld_bytes;
  logic        wb_busy, wb_overflow, fwd_hit;
  logic [31:0] fwd_data;
  int          total = 0;
  int          bad = 0;

  writeback_if wb_bus ();

  writeback dut (
    .clk(clk), .reset(reset), .run(run),
    .ex_we(ex_we), .ex_rd(ex_rd), .ex_data(ex_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_addr_lo(ld_addr_lo),
    .ld_bytes(ld_bytes), .ld_unsigned(ld_unsigned),
    .div_ready(div_ready), .div_rd(div_rd), .div_data(div_data),
    .wb(wb_bus), .wb_busy(wb_busy), .wb_overflow(wb_overflow),
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_we = 1'b0; ex_rd = 5'd0; ex_data = 32'd0;
    ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0; ld_addr_lo = 2'd0;
    ld_bytes = 2'd2; ld_unsigned = 1'b0;
    div_ready = 1'b0; div_rd = 5'd0; div_data = 32'd0;
  endtask

  // Three results in one cycle, data = 0x100 + rd, load as a plain word.
  task automatic push3(input logic [4:0] d, input logic [4:0] l, input logic [4:0] e);
    div_ready = 1'b1; div_rd = d; div_data = 32'h100 + {27'd0, d};
    ld_valid = 1'b1; ld_rd = l; ld_data = 32'h100 + {27'd0, l}; ld_bytes = 2'd2;
    ex_we = 1'b1; ex_rd = e; ex_data = 32'h100 + {27'd0, e};
  endtask

  initial begin
    idle();
    reset = 1'b1; run = 1'b0; fwd_rs = 5'd0;
    tick(); tick();
    chk("rst_we", {31'd0, wb_bus.reg_we_out}, 32'd0);
    chk("rst_rd", {27'd0, wb_bus.rd_out}, 32'd0);
    chk("rst_wdata", wb_bus.reg_wdata, 32'd0);
    chk("rst_busy", {31'd0, wb_busy}, 32'd0);
    chk("rst_ovf", {31'd0, wb_overflow}, 32'd0);
    chk("rst_fwd_hit", {31'd0, fwd_hit}, 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);

    // Lone EX result: one-cycle latency.
    reset = 1'b0; run = 1'b1;
    ex_we = 1'b1; ex_rd = 5'd5; ex_data = 32'h1234;
    tick(); idle();
    chk("ex_we", {31'd0, wb_bus.reg_we_out}, 32'd1);
    chk("ex_rd", {27'd0, wb_bus.rd_out}, 32'd5);
    chk("ex_data", wb_bus.reg_wdata, 32'h1234);
    tick();
    chk("ex_we_off", {31'd0, wb_bus.reg_we_out}, 32'd0);
    chk("ex_rd_hold", {27'd0, wb_bus.rd_out}, 32'd5);

    // Load formatting.
    ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'h80FF7F01; ld_addr_lo = 2'd3;
    ld_bytes = 2'd0; ld_unsigned = 1'b0;
    tick(); idle();
    chk("ld_byte_s3_rd", {27'd0, wb_bus.rd_out}, 32'd10);
    chk("ld_byte_s3", wb_bus.reg_wdata, 32'hFFFFFF80);
    ld_valid = 1'b1; ld_rd = 5'd11; ld_data = 32'h80FF7F01; ld_addr_lo = 2'd2;
    ld_bytes = 2'd1; ld_unsigned = 1'b1;
    tick(); idle();
    chk("ld_half_u2", wb_bus.reg_wdata, 32'h000080FF);
    ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'h80FF7F01; ld_addr_lo = 2'd1;
    ld_bytes = 2'd0; ld_unsigned = 1'b1;
    tick(); idle();
    chk("ld_byte_u1", wb_bus.reg_wdata, 32'h0000007F);
    ld_valid = 1'b1; ld_rd = 5'd13; ld_data = 32'h80FF7F01; ld_addr_lo = 2'd2;
    ld_bytes = 2'd1; ld_unsigned = 1'b0;
    tick(); idle();
    chk("ld_half_s2", wb_bus.reg_wdata, 32'hFFFF80FF);
    ld_valid = 1'b1; ld_rd = 5'd14; ld_data = 32'h80FF7F01; ld_addr_lo = 2'd1;
    ld_bytes = 2'd3; ld_unsigned = 1'b0;
    tick(); idle();
    chk("ld_word", wb_bus.reg_wdata, 32'h80FF7F01);
    tick();

    // DIV, LD, EX in one cycle drain in that order.
    push3(5'd3, 5'd4, 5'd5);
    tick(); idle();
    chk("ord0_rd", {27'd0, wb_bus.rd_out}, 32'd3);
    chk("ord0_data", wb_bus.reg_wdata, 32'h103);
    chk("ord0_busy", {31'd0, wb_busy}, 32'd1);
    tick();
    chk("ord1_rd", {27'd0, wb_bus.rd_out}, 32'd4);
    chk("ord1_we", {31'd0, wb_bus.reg_we_out}, 32'd1);
    chk("ord1_busy", {31'd0, wb_busy}, 32'd0);
    tick();
    chk("ord2_rd", {27'd0, wb_bus.rd_out}, 32'd5);
    chk("ord2_data", wb_bus.reg_wdata, 32'h105);
    tick();
    chk("ord_done_we", {31'd0, wb_bus.reg_we_out}, 32'd0);

    // rd==0 is discarded silently.
    ex_we = 1'b1; ex_rd = 5'd0; ex_data = 32'hDEAD;
    tick(); idle();
    chk("rd0_we", {31'd0, wb_bus.reg_we_out}, 32'd0);
    chk("rd0_ovf", {31'd0, wb_overflow}, 32'd0);

    // Two pending writes to x7: forwarding returns the younger one.
    div_ready = 1'b1; div_rd = 5'd7; div_data = 32'h11;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h22; ld_bytes = 2'd2;
    fwd_rs = 5'd7;
    tick(); idle();
    chk("fwd_out_data", wb_bus.reg_wdata, 32'h11);
`ifdef WB_FORWARD_EN
    chk("fwd7_hit", {31'd0, fwd_hit}, 32'd1);
    chk("fwd7_data", fwd_data, 32'h22);
`else
    chk("fwd7_hit", {31'd0, fwd_hit}, 32'd0);
    chk("fwd7_data", fwd_data, 32'd0);
`endif
    fwd_rs = 5'd0; #1;
    chk("fwd0_hit", {31'd0, fwd_hit}, 32'd0);
    fwd_rs = 5'd9; #1;
    chk("fwd9_hit", {31'd0, fwd_hit}, 32'd0);
    fwd_rs = 5'd7;
    tick();
    chk("fwd_pop_data", wb_bus.reg_wdata, 32'h22);
`ifdef WB_FORWARD_EN
    chk("fwd_outreg_hit", {31'd0, fwd_hit}, 32'd1);
    chk("fwd_outreg_data", fwd_data, 32'h22);
`else
    chk("fwd_outreg_hit", {31'd0, fwd_hit}, 32'd0);
`endif
    tick();
    chk("fwd_idle_hit", {31'd0, fwd_hit}, 32'd0);

    // Overfill, hold with run=0, then reset mid-drain.
    push3(5'd1, 5'd2, 5'd3);
    tick();
    chk("fill0_rd", {27'd0, wb_bus.rd_out}, 32'd1);
    push3(5'd4, 5'd5, 5'd6);
    tick();
    chk("fill1_rd", {27'd0, wb_bus.rd_out}, 32'd2);
    chk("fill1_ovf", {31'd0, wb_overflow}, 32'd0);
    push3(5'd7, 5'd8, 5'd9);
    tick(); idle();
    chk("fill2_rd", {27'd0, wb_bus.rd_out}, 32'd3);
    chk("fill2_ovf", {31'd0, wb_overflow}, 32'd1);
    chk("fill2_busy", {31'd0, wb_busy}, 32'd1);
    run = 1'b0;
    push3(5'd10, 5'd11, 5'd12);
    tick(); tick(); idle();
    chk("hold_we", {31'd0, wb_bus.reg_we_out}, 32'd0);
    chk("hold_rd", {27'd0, wb_bus.rd_out}, 32'd3);
    chk("hold_ovf", {31'd0, wb_overflow}, 32'd1);
    chk("hold_busy", {31'd0, wb_busy}, 32'd1);
    fwd_rs = 5'd6; #1;
`ifdef WB_FORWARD_EN
    chk("hold_fwd6", fwd_data, 32'h106);
`else
    chk("hold_fwd6", fwd_data, 32'd0);
`endif
    fwd_rs = 5'd8; #1;
    chk("hold_fwd8_hit", {31'd0, fwd_hit}, 32'd0);
    fwd_rs = 5'd0;
    run = 1'b1;
    tick();
    chk("drain0_rd", {27'd0, wb_bus.rd_out}, 32'd4);
    tick();
    chk("drain1_rd", {27'd0, wb_bus.rd_out}, 32'd5);
    chk("drain1_data", wb_bus.reg_wdata, 32'h105);
    reset = 1'b1;
    tick();
    chk("mrst_we", {31'd0, wb_bus.reg_we_out}, 32'd0);
    chk("mrst_rd", {27'd0, wb_bus.rd_out}, 32'd0);
    chk("mrst_ovf", {31'd0, wb_overflow}, 32'd0);
    chk("mrst_busy", {31'd0, wb_busy}, 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_we", {31'd0, wb_bus.reg_we_out}, 32'd0);
    tick();
    chk("post_rst_we2", {31'd0, wb_bus.reg_we_out}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
